// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC, imem req/ack handshake, IF/ID register
// Single outstanding fetch; a fetched word is parked in buf_q while decode stalls.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_i,
    input  logic        branch_flag_i,
    input  logic [15:0] branch_addr_i,
    input  logic        mem_busy_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_rdata_i,
    output logic [15:0] pc_o,
    output logic [15:0] inst_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] buf_q, buf_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic [15:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic        ack_v;
    logic        advance;
    logic [15:0] inst_src;
    logic [15:0] pc_inc;

    assign pc_inc       = pc_q + 16'd1;
    assign imem_addr_o  = pc_q;
    // mem_busy_i only blocks a new request; an issued one stays up until ack
    assign imem_req_o   = !rst && ((state_q == S_FETCH && !mem_busy_i) || state_q == S_WAIT);
    assign ack_v        = imem_req_o && imem_ack_i;
    assign inst_src     = (state_q == S_HOLD) ? buf_q : imem_rdata_i;
    assign advance      = (ack_v || state_q == S_HOLD) && !stall_req_i;

    assign pc_o         = pc_out_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        pc_out_d = pc_out_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        if (advance) begin
            inst_d   = inst_src;
            pc_out_d = pc_inc;
            valid_d  = 1'b1;
            pc_d     = branch_flag_i ? branch_addr_i : pc_inc;
            state_d  = S_FETCH;
        end else if (ack_v) begin
            buf_d   = imem_rdata_i;
            state_d = S_HOLD;
        end else if (imem_req_o) begin
            state_d = S_WAIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            buf_q    <= NOP_INST;
            pc_out_q <= 16'h0000;
            inst_q   <= NOP_INST;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            pc_out_q <= pc_out_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 16-bit MIPS16-style pipeline, directly upstream of the decode stage.
- Owns the PC and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Drives the IF/ID pipeline register (`pc_o`, `inst_o`, `inst_valid_o`) that feeds decode.
- Applies decode's stall request and branch redirect, with a one-instruction delay slot.

Parameters:
- RESET_PC, 16'h0000, fetch address after reset.
- NOP_INST, 16'h0800, encoding placed in `inst_o` when no valid instruction is present.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall_req_i  in  1  decode cannot accept a new instruction this cycle
- branch_flag_i  in  1  decode resolves a taken branch/jump for the instruction currently in ID
- branch_addr_i  in  16  branch target
- mem_busy_i  in  1  MEM stage owns the shared SRAM this cycle; no new fetch may start
- imem_req_o  out  1  fetch request
- imem_addr_o  out  16  fetch word address
- imem_ack_i  in  1  `imem_rdata_i` valid; may be asserted in the same cycle as req (zero-wait)
- imem_rdata_i  in  16  fetched instruction
- pc_o  out  16  IF/ID register: fetch address + 1 (value decode uses as `pc_i`)
- inst_o  out  16  IF/ID register: instruction
- inst_valid_o  out  1  IF/ID register holds a real instruction

Behaviour:
- States: FETCH, WAIT, HOLD.
- Registers: `pc` (16 b), `buf_inst` (16 b).
- `imem_addr_o` = `pc` at all times.
- `imem_req_o` = (FETCH and !mem_busy_i) or WAIT.
- Once a request is issued, req and addr stay stable until ack, regardless of `mem_busy_i`.
- `imem_ack_i` is ignored while `imem_req_o` = 0.
- Advance event: the IF/ID register loads, and `pc` updates, only on an advance. An advance occurs when an instruction is available and `stall_req_i` = 0. "Available" means:
  - ack this cycle in FETCH or WAIT (data from `imem_rdata_i`), or
  - state HOLD (data from `buf_inst`).
- On advance:
  - `inst_o` <= instruction; `pc_o` <= `pc`+1; `inst_valid_o` <= 1.
  - `pc` <= `branch_addr_i` if `branch_flag_i`, else `pc`+1.
  - Next state is FETCH.
- Delay slot: the instruction entering ID on the advance that retires a taken branch is the delay slot and is never squashed.
- `branch_flag_i` is sampled only on advance cycles.
- FETCH transitions:
  - `mem_busy_i` -> stay, req 0.
  - req with no ack -> WAIT.
  - ack and stall -> HOLD, `buf_inst` <= `imem_rdata_i`.
  - ack and no stall -> advance, stay FETCH.
  - Zero-wait memory gives 1 instruction/cycle.
- WAIT transitions:
  - no ack -> stay.
  - ack and stall -> HOLD, `buf_inst` <= `imem_rdata_i`.
  - ack and no stall -> advance, FETCH.
- HOLD:
  - req 0.
  - Advance when `stall_req_i` = 0; otherwise stay.
- While not advancing, `pc_o`/`inst_o`/`inst_valid_o` hold their values; decode sees the same instruction while stalled.
- No prefetch: at most one outstanding request. The next fetch starts only after an advance, since the next PC depends on decode's branch.
- PC arithmetic: 16-bit modulo; 16'hFFFF + 1 = 16'h0000. No overflow flag.
- Reset (sync, also mid-WAIT or mid-HOLD):
  - `pc` <= RESET_PC; state <= FETCH; `buf_inst` <= NOP_INST.
  - `inst_o` <= NOP_INST; `pc_o` <= 16'h0000; `inst_valid_o` <= 0.
  - `imem_req_o` = 0 during reset cycles.
  - A pending ack during reset is discarded.
- Simultaneous stall and branch: stall wins; no advance; branch re-sampled at the later advance.
- Simultaneous `mem_busy_i` and ack in WAIT: ack accepted normally.

Test Plan:
- Reset, zero-wait memory returning mem[a] = 16'h4000+a, no stall -> `imem_addr_o` 0,1,2,3 on consecutive cycles. One cycle later `inst_o` = 4000, 4001, 4002 with `pc_o` = 1, 2, 3; `inst_valid_o` = 1.
- Memory with 2 wait cycles -> `imem_req_o` high 3 cycles with `imem_addr_o` stable. `inst_o` updates every 3 cycles; `pc_o` increments by 1 each update.
- `stall_req_i` = 1 for 4 cycles while ack arrives at addr 5 -> state HOLD, req 0, `inst_o` frozen. Inst 5 loads on the first unstalled cycle; next request addr 6.
- Branch: ID holds branch at pc_o = 3, `branch_flag_i` = 1, `branch_addr_i` = 16'h0020 -> delay slot (addr 3) enters ID. The next fetch address is 16'h0020, not 4.
- `mem_busy_i` high 2 cycles in FETCH -> req 0 for those cycles, then fetch resumes at the same `pc`. Asserting `mem_busy_i` during WAIT does not drop the request.
- Assert rst during WAIT at pc = 16'h0010 -> next cycle req 0, `inst_valid_o` = 0, `inst_o` = 16'h0800. After release, the first fetch is at RESET_PC.
